// File: rtl/selector_8_pkg.sv
// rtl/selector_8_pkg.sv - shared widths for the 8-to-256 one-hot selector
package selector_8_pkg;

    localparam int ADDR_W = 8;
    localparam int OUT_W  = 256;
    localparam int NIB_W  = 4;
    localparam int PRE_W  = 16;

endpackage

// File: rtl/selector_8_if.sv
// rtl/selector_8_if.sv - address in / one-hot select out bundle for selector_8
interface selector_8_if;
    import selector_8_pkg::*;

    logic [ADDR_W-1:0] addr;
    logic [OUT_W-1:0]  decoded;

    // master produces addresses and consumes selects; slave is the decoder
    modport master (output addr, input decoded);
    modport slave  (input addr, output decoded);

endinterface

// File: rtl/selector_8_decoder.sv
// rtl/selector_8_decoder.sv - combinational 4-to-16 one-hot predecoder
module decoder_4to16
    import selector_8_pkg::*;
(
    input  logic [NIB_W-1:0] nib,
    output logic [PRE_W-1:0] oh
);

    // exactly one predecode line high for every nibble value
    always_comb begin
        oh      = '0;
        oh[nib] = 1'b1;
    end

endmodule

// File: rtl/selector_8.sv
// rtl/selector_8.sv - registered 8-bit to 256-line one-hot selector (option: SELECTOR_8_PIPE_EN adds a predecode register stage)
module selector_8
    import selector_8_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    selector_8_if.slave  bus
);

    logic [NIB_W-1:0] hi_nib;
    logic [NIB_W-1:0] lo_nib;
    logic [PRE_W-1:0] hi_oh;
    logic [PRE_W-1:0] lo_oh;
    logic [PRE_W-1:0] hi_q;
    logic [PRE_W-1:0] lo_q;
    logic [OUT_W-1:0] matrix;
    logic [OUT_W-1:0] decoded_q;

    assign hi_nib = bus.addr[ADDR_W-1:NIB_W];
    assign lo_nib = bus.addr[NIB_W-1:0];

    decoder_4to16 u_dec_hi (
        .nib (hi_nib),
        .oh  (hi_oh)
    );

    decoder_4to16 u_dec_lo (
        .nib (lo_nib),
        .oh  (lo_oh)
    );

`ifdef SELECTOR_8_PIPE_EN
    // extra stage between predecoders and the AND matrix; all-zero in reset
    // keeps the matrix output zero until a real address has passed through
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_oh;
            lo_q <= lo_oh;
        end
    end
`else
    assign hi_q = hi_oh;
    assign lo_q = lo_oh;
`endif

    // 16x16 AND matrix: line 16*h+l is selected when both predecode lines are high
    for (genvar h = 0; h < PRE_W; h++) begin : g_hi
        for (genvar l = 0; l < PRE_W; l++) begin : g_lo
            assign matrix[h*PRE_W + l] = hi_q[h] & lo_q[l];
        end
    end

    // output register so consumers see glitch-free selects straight from flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            decoded_q <= '0;
        end else begin
            decoded_q <= matrix;
        end
    end

    assign bus.decoded = decoded_q;

endmodule

// File: tb/tb_selector_8.sv
// tb/tb_selector_8.sv - randomized self-checking bench for selector_8
module tb_selector_8;

`ifdef SELECTOR_8_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    int   hist[$];

    selector_8_if bus ();

    selector_8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // apply one address, let one edge pass, compare against the address history
    task automatic step(input logic [7:0] a);
        logic [255:0] exp_v;
        int           j;
        bus.addr = a;
        @(posedge clk);
        if (rst_n) hist.push_back(int'(a));
        else hist.delete();
        #1;
        exp_v = '0;
        j = -1;
        if (hist.size() >= LAT) begin
            j = hist[hist.size() - LAT];
            exp_v[j] = 1'b1;
        end
        check("decoded", bus.decoded, exp_v);
        if (j >= 0) begin
            check("popcount", 256'($countones(bus.decoded)), 256'd1);
            if (j > 0)   check("line_below", {255'b0, bus.decoded[j-1]}, 256'd0);
            if (j < 255) check("line_above", {255'b0, bus.decoded[j+1]}, 256'd0);
        end
        @(negedge clk);
    endtask

    // drop reset between edges, confirm the clear is immediate, hold, release
    task automatic async_reset(input int hold_edges);
        #2;
        rst_n = 1'b0;
        hist.delete();
        #1;
        check("async_clear", bus.decoded, 256'd0);
        bus.addr = 8'h37;
        for (int k = 0; k < hold_edges; k++) begin
            @(posedge clk);
            #1;
            check("in_reset", bus.decoded, 256'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        rst_n    = 1'b0;
        bus.addr = 8'h37;

        #1;
        check("reset_state", bus.decoded, 256'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("in_reset", bus.decoded, 256'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < LAT; k++) step(8'h37);

        step(8'h01);
        step(8'h00);
        step(8'hFF);
        step(8'h0F);
        step(8'h10);
        for (int k = 0; k < LAT; k++) step(8'h10);

        for (int i = 0; i < 256; i++) begin
            step(8'(i));
            if (i == 100) async_reset(2);
        end

        for (int k = 0; k < 20; k++) step(8'($urandom % 256));
        for (int k = 0; k < LAT; k++) step(8'h5A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
